// File: rtl/shift_pkg.sv
// Shared constants for the registered ALU barrel shifter: data width and shift-mode codes.
package shift_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [1:0] ALUC_SRA = 2'b00;
  localparam logic [1:0] ALUC_SRL = 2'b01;
  localparam logic [1:0] ALUC_SLL = 2'b10;
  localparam logic [1:0] ALUC_SLA = 2'b11;

endpackage

// File: rtl/barrel_shift_stage.sv
// One level of the logarithmic shifter: conditionally shifts by a fixed distance.
module barrel_shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned Width = WIDTH,
  parameter int unsigned Shift = 1
) (
  input  logic [Width-1:0] data_i,
  input  logic             en_i,
  input  logic             left_i,
  input  logic             fill_i,
  output logic [Width-1:0] data_o
);

  localparam logic [Width-1:0] Ones = {Width{1'b1}};

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      if (left_i) begin
        data_o = data_i << Shift;
      end else begin
        data_o = data_i >> Shift;
        // Vacated MSBs take the fill bit (sign for arithmetic right shifts).
        if (fill_i) begin
          data_o = data_o | ~(Ones >> Shift);
        end
      end
    end
  end

endmodule

// File: rtl/barrel_shifter32.sv
// Registered 32-bit barrel shifter: five mux stages (1,2,4,8,16) into a single output register.
module barrel_shifter32
  import shift_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] b,
  input  logic [1:0]         aluc,
  output logic [WIDTH-1:0]   c,
  output logic               out_valid
);

  logic             left;
  logic             fill;
  logic [WIDTH-1:0] stage_data [SHAMT_W+1];
  logic [WIDTH-1:0] c_d, c_q;
  logic             out_valid_d, out_valid_q;

  // SLL and SLA are the same operation; only SRA fills with the sign bit.
  assign left          = aluc[1];
  assign fill          = (aluc == ALUC_SRA) & a[WIDTH-1];
  assign stage_data[0] = a;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    barrel_shift_stage #(
      .Width (WIDTH),
      .Shift (1 << k)
    ) u_stage (
      .data_i (stage_data[k]),
      .en_i   (b[k]),
      .left_i (left),
      .fill_i (fill),
      .data_o (stage_data[k+1])
    );
  end

  always_comb begin
    c_d         = c_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      c_d = stage_data[SHAMT_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign c         = c_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_barrel_shifter32.sv
// Self-checking bench for barrel_shifter32: directed and random shifts against an arithmetic model.
module tb_barrel_shifter32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [4:0]  b;
  logic [1:0]  aluc;
  logic [31:0] c;
  logic        out_valid;

  int unsigned tests;
  int unsigned fails;
  logic [31:0] last_c;

  barrel_shifter32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .aluc      (aluc),
    .c         (c),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] s,
                                            input logic [1:0] mode);
    logic signed [31:0] sx;
    sx = x;
    case (mode)
      2'b00:   return sx >>> s;
      2'b01:   return x >> s;
      default: return x << s;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operation, then check result and valid one edge later.
  task automatic issue(input logic [31:0] ia, input logic [4:0] ib, input logic [1:0] im,
                       input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    aluc     = im;
    @(posedge clk);
    #1;
    last_c = ref_shift(ia, ib, im);
    check(tag, c, last_c);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = 5'($urandom_range(0, 31));
    aluc     = 2'($urandom_range(0, 3));
    @(posedge clk);
    #1;
    check(tag, c, last_c);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    last_c   = '0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    aluc     = '0;

    #2;
    check("reset_c", c, 32'h0);
    check("reset_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream, then async reset in the middle of it.
    issue(32'h1234_5678, 5'd3, 2'b10, "pre_rst0");
    issue(32'h8765_4321, 5'd7, 2'b00, "pre_rst1");
    @(negedge clk);
    a     = 32'hDEAD_BEEF;
    b     = 5'd1;
    rst_n = 1'b0;
    #1;
    check("midrst_c", c, 32'h0);
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_held_c", c, 32'h0);
    check("rst_held_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    last_c   = '0;
    @(posedge clk);
    #1;
    check("post_rst_valid", {31'b0, out_valid}, 32'd0);
    check("post_rst_c", c, 32'h0);
    issue(32'hA5F0_C3E7, 5'd1, 2'b01, "first_after_rst");

    // b=0 passes a through in every mode.
    for (int m = 0; m < 4; m++) begin
      issue(32'hA5F0_C3E7, 5'd0, 2'(m), "b0");
      check("b0_const", c, 32'hA5F0_C3E7);
    end

    issue(32'hA5F0_C3E7, 5'd4, 2'b00, "b4_sra");
    check("b4_sra_const", c, 32'hFA5F_0C3E);
    issue(32'hA5F0_C3E7, 5'd4, 2'b01, "b4_srl");
    check("b4_srl_const", c, 32'h0A5F_0C3E);
    issue(32'hA5F0_C3E7, 5'd4, 2'b10, "b4_sll");
    check("b4_sll_const", c, 32'h5F0C_3E70);
    issue(32'hA5F0_C3E7, 5'd4, 2'b11, "b4_sla");
    check("b4_sla_const", c, 32'h5F0C_3E70);

    issue(32'hA5F0_C3E7, 5'd31, 2'b00, "b31_sra");
    check("b31_sra_const", c, 32'hFFFF_FFFF);
    issue(32'hA5F0_C3E7, 5'd31, 2'b01, "b31_srl");
    check("b31_srl_const", c, 32'h0000_0001);
    issue(32'hA5F0_C3E7, 5'd31, 2'b10, "b31_sll");
    check("b31_sll_const", c, 32'h8000_0000);

    // Back-to-back sweep over all amounts and modes.
    for (int p = 0; p < 2; p++) begin
      for (int m = 0; m < 4; m++) begin
        for (int s = 0; s < 32; s++) begin
          issue((p == 0) ? 32'hA5F0_C3E7 : 32'h5A0F_3C18, 5'(s), 2'(m), "sweep");
          if (p == 0 && m == 0 && s == 16) check("spot_sra16", c, 32'hFFFF_A5F0);
          if (p == 0 && m == 2 && s == 8)  check("spot_sll8", c, 32'hF0C3_E700);
        end
      end
    end

    for (int i = 0; i < 4; i++) idle("hold");

    for (int i = 0; i < 64; i++) begin
      issue($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), "random");
      if ($urandom_range(0, 3) == 0) idle("rand_hold");
    end
    idle("final_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
